// File: rtl/i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cmd_sequencer
//
// Command queue and issue controller that sits in front of an I2C master.
// Single-byte commands (7-bit address, R/W, data byte) are buffered in a
// FIFO and handed to the master one transaction at a time. The block tracks
// the master's busy/done handshake. Read results and watchdog errors come
// back through a one-entry valid/ready response register.
//
// Build option:
//   I2C_SEQ_TIMEOUT_EN - when defined, a per-transaction watchdog aborts a
//                        transaction after TIMEOUT_CYCLES clocks and reports
//                        it with o_rsp_err=1. When undefined, the sequencer
//                        waits indefinitely and o_rsp_err is tied low.
//
// Parameters:
//   DEPTH          - command FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES - watchdog limit in clocks (only used with the option)
//
// Ports:
//   i_clk, i_rst        - clock; synchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_addr/i_cmd_rw/i_cmd_data
//                       - command push interface (rw: 0 write, 1 read)
//   o_rsp_valid/i_rsp_ready, o_rsp_data, o_rsp_err
//                       - response interface (read byte or timeout error)
//   o_m_start, o_m_addr, o_m_rw, o_m_data
//                       - request outputs to the I2C master
//   i_m_busy, i_m_done, i_m_data_out
//                       - status and read data from the I2C master
//   o_fifo_level        - number of queued commands
//   o_idle              - FSM idle and FIFO empty
// ---------------------------------------------------------------------------
module i2c_cmd_sequencer #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [6:0]               i_cmd_addr,
  input  logic                     i_cmd_rw,
  input  logic [7:0]               i_cmd_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [7:0]               o_rsp_data,
  output logic                     o_rsp_err,
  output logic                     o_m_start,
  output logic [6:0]               o_m_addr,
  output logic                     o_m_rw,
  output logic [7:0]               o_m_data,
  input  logic                     i_m_busy,
  input  logic                     i_m_done,
  input  logic [7:0]               i_m_data_out,
  output logic [$clog2(DEPTH):0]   o_fifo_level,
  output logic                     o_idle
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 16;
  localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(DEPTH);

  // Reject parameter values the pointer arithmetic cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
    $error("i2c_cmd_sequencer: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
    $error("i2c_cmd_sequencer: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DRAIN
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;

  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [PTR_W:0]       r_level;

  logic                 r_doneQ;
  logic                 r_start;
  logic [6:0]           r_addr;
  logic                 r_rw;
  logic [7:0]           r_data;

  logic                 r_rspValid;
  logic [7:0]           r_rspData;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_doneRise;
  logic                 w_timeout;
  logic                 w_startClr;
  logic                 w_rspLoad;
  logic                 w_rspErr;
  logic [ENTRY_W-1:0]   w_head;

  // A full FIFO refuses pushes outright, so a dropped push touches nothing.
  assign o_cmd_ready = (r_level < LEVEL_FULL);
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_head      = r_mem[r_rdPtr];

  // The master holds done high until its next idle tick, so only the
  // rising edge marks completion of the current transaction.
  assign w_doneRise  = i_m_done && !r_doneQ;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_rspErr;

  // Watchdog: cleared on every pop, counts only while a transaction is
  // outstanding. Reaching the last count aborts the transaction on the
  // following edge, giving exactly TIMEOUT_CYCLES clocks from pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wdog <= '0;
    end else if (w_pop) begin
      r_wdog <= '0;
    end else if (r_state == ST_ISSUE || r_state == ST_WAIT_DONE) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_ISSUE || r_state == ST_WAIT_DONE) &&
                     (r_wdog == WDOG_LAST);

  // Error flag travels with each response load.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rspErr <= 1'b0;
    end else if (w_rspLoad) begin
      r_rspErr <= w_rspErr;
    end
  end

  assign o_rsp_err = r_rspErr;
`else
  assign w_timeout = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  // State register plus the done-edge history register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_doneQ <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_doneQ <= i_m_done;
    end
  end

  // Next-state and control strobes. A new command is only popped while no
  // response is pending, which is what keeps the one-entry response
  // register from ever being overrun.
  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_startClr  = 1'b0;
    w_rspLoad   = 1'b0;
    w_rspErr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_level != '0 && !r_rspValid) begin
          w_pop       = 1'b1;
          w_stateNext = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // start is held because the master only samples it while SCL is low
        if (w_timeout) begin
          w_startClr  = 1'b1;
          w_rspLoad   = 1'b1;
          w_rspErr    = 1'b1;
          w_stateNext = ST_IDLE;
        end else if (i_m_busy) begin
          w_startClr  = 1'b1;
          w_stateNext = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // a done edge arriving on the last watchdog cycle still counts
        if (w_doneRise) begin
          w_rspLoad   = r_rw;
          w_stateNext = ST_DRAIN;
        end else if (w_timeout) begin
          w_rspLoad   = 1'b1;
          w_rspErr    = 1'b1;
          w_stateNext = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // wait for done to fall so the next transaction sees a clean edge
        if (!i_m_done) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is
  // a power of two; push and pop in the same cycle leave the level alone.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {i_cmd_addr, i_cmd_rw, i_cmd_data};
    end
  end

  // Request registers to the master. Address/rw/data are only rewritten on
  // a pop so they stay stable for the whole transaction and beyond.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_start <= 1'b0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_data  <= '0;
    end else if (w_pop) begin
      r_start <= 1'b1;
      r_addr  <= w_head[15:9];
      r_rw    <= w_head[8];
      r_data  <= w_head[7:0];
    end else if (w_startClr) begin
      r_start <= 1'b0;
    end
  end

  // Response register. Error responses carry a zero data byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
    end else if (w_rspLoad) begin
      r_rspValid <= 1'b1;
      r_rspData  <= w_rspErr ? 8'h00 : i_m_data_out;
    end else if (r_rspValid && i_rsp_ready) begin
      r_rspValid <= 1'b0;
    end
  end

  assign o_rsp_valid  = r_rspValid;
  assign o_rsp_data   = r_rspData;
  assign o_m_start    = r_start;
  assign o_m_addr     = r_addr;
  assign o_m_rw       = r_rw;
  assign o_m_data     = r_data;
  assign o_fifo_level = r_level;
  assign o_idle       = (r_state == ST_IDLE) && (r_level == '0);

endmodule
